// File: rtl/frogger_pkg.sv
// Shared keycodes, direction/state encodings and helpers for the Frogger input path.
package frogger_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'd0,
        DIR_DOWN  = 2'd1,
        DIR_LEFT  = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT
    } move_state_t;

    localparam logic [7:0] KEY_UP       = 8'h52;
    localparam logic [7:0] KEY_DOWN     = 8'h51;
    localparam logic [7:0] KEY_LEFT     = 8'h50;
    localparam logic [7:0] KEY_RIGHT    = 8'h4F;
    localparam logic [7:0] KEY_SEL_BASE = 8'h59;
    localparam logic [7:0] KEY_NEXT     = 8'h2B;

    function automatic logic [3:0] dir_onehot(input dir_t d);
        return 4'b0001 << d;
    endfunction

endpackage

// File: rtl/frame_sync_edge.sv
// Synchronises frame_clk into the Clk domain and detects its rising edge.
module frame_sync_edge (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic edge_now,
    output logic frame_tick
);

    logic sync1, sync2, sync3;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            sync3      <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            sync1      <= frame_clk;
            sync2      <= sync1;
            sync3      <= sync2;
            frame_tick <= sync2 & ~sync3;
        end
    end

    // Unregistered edge lets consumers register results into the same cycle as frame_tick.
    assign edge_now = sync2 & ~sync3;

endmodule

// File: rtl/frogger_input_ctrl.sv
// Keyboard front-end: frame-aligned move pulses with hold-to-repeat and one-hot frog selection.
module frogger_input_ctrl
    import frogger_pkg::*;
#(
    parameter int unsigned NUM_FROGS    = 3,
    parameter logic [7:0]  SEL_KEY_BASE = KEY_SEL_BASE,
    parameter logic [7:0]  NEXT_KEY     = KEY_NEXT,
    parameter int unsigned REPEAT_DELAY = 20,
    parameter int unsigned REPEAT_RATE  = 6
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 frame_clk,
    input  logic [15:0]          keycode,
    output logic                 frame_tick,
    output logic                 move_up,
    output logic                 move_down,
    output logic                 move_left,
    output logic                 move_right,
    output logic [3:0]           dir_held,
    output logic [1:0]           last_dir,
    output logic [NUM_FROGS-1:0] active_frog,
    output logic                 sel_valid
);

    localparam logic [5:0] DELAY_LD = 6'(REPEAT_DELAY);
    localparam logic [5:0] RATE_LD  = 6'(REPEAT_RATE);
    localparam logic [7:0] NF8      = 8'(NUM_FROGS);

    logic tick_now;

    frame_sync_edge u_sync (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .edge_now   (tick_now),
        .frame_tick (frame_tick)
    );

    logic key_valid;
    logic dir_present;
    dir_t key_dir;

    assign key_valid = (keycode[15:8] == 8'h00);

    always_comb begin
        dir_present = 1'b0;
        key_dir     = DIR_UP;
        if (key_valid) begin
            case (keycode[7:0])
                KEY_UP:    begin dir_present = 1'b1; key_dir = DIR_UP;    end
                KEY_DOWN:  begin dir_present = 1'b1; key_dir = DIR_DOWN;  end
                KEY_LEFT:  begin dir_present = 1'b1; key_dir = DIR_LEFT;  end
                KEY_RIGHT: begin dir_present = 1'b1; key_dir = DIR_RIGHT; end
                default:   ;
            endcase
        end
    end

    move_state_t state;
    logic [5:0]  cnt;
    logic [3:0]  pulse;
    dir_t        last_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            pulse    <= '0;
            last_d   <= DIR_UP;
            dir_held <= '0;
        end else begin
            pulse <= '0;
            if (tick_now) begin
                dir_held <= dir_present ? dir_onehot(key_dir) : 4'b0000;
                if (!dir_present) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else if (state == IDLE || key_dir != last_d) begin
                    pulse  <= dir_onehot(key_dir);
                    last_d <= key_dir;
                    cnt    <= DELAY_LD;
                    state  <= DELAY;
                end else if (cnt == 6'd1) begin
                    pulse <= dir_onehot(last_d);
                    if (RATE_LD == 6'd0) begin
                        cnt   <= '0;
                        state <= DELAY;
                    end else begin
                        cnt   <= RATE_LD;
                        state <= REPEAT;
                    end
                end else if (cnt != 6'd0) begin
                    cnt <= cnt - 6'd1;
                end
            end
        end
    end

    assign last_dir   = last_d;
    assign move_up    = pulse[0] & sel_valid;
    assign move_down  = pulse[1] & sel_valid;
    assign move_left  = pulse[2] & sel_valid;
    assign move_right = pulse[3] & sel_valid;

    logic [15:0]          prev_key;
    logic [7:0]           sel_idx;
    logic [NUM_FROGS-1:0] frog_rot, frog_sel, frog_nxt;

    assign sel_idx = keycode[7:0] - SEL_KEY_BASE;

    always_comb begin
        frog_rot = '0;
        frog_sel = '0;
        if (active_frog == '0) begin
            frog_rot[0] = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NUM_FROGS; i++) begin
                frog_rot[(i + 1) % NUM_FROGS] = active_frog[i];
            end
        end
        for (int unsigned i = 0; i < NUM_FROGS; i++) begin
            frog_sel[i] = (sel_idx == 8'(i));
        end
        frog_nxt = active_frog;
        if (key_valid) begin
            if (keycode[7:0] == NEXT_KEY) begin
                if (prev_key != keycode) frog_nxt = frog_rot;
            end else if (keycode[7:0] >= SEL_KEY_BASE && sel_idx < NF8) begin
                frog_nxt = frog_sel;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            active_frog <= '0;
            prev_key    <= '0;
        end else begin
            active_frog <= frog_nxt;
            prev_key    <= keycode;
        end
    end

    assign sel_valid = |active_frog;

endmodule
